mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for one ram data port, one op in flight.
// Optional MEM_ARB_LOCK_EN: per-requester lock giving exclusive back-to-back access.
module mem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [1:0]        m0_wsize,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [1:0]        m1_wsize,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       dw_data,
  output logic [1:0]        dw_size,
  input  logic [31:0]       d_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;

  logic elig0, elig1;
  logic win, take;

`ifdef MEM_ARB_LOCK_EN
  logic lk_v_q, lk_v_d;
  logic lk_id_q, lk_id_d;
  logic win_lock;

  // While locked only the owner may compete.
  assign elig0 = m0_req & (~lk_v_q | ~lk_id_q);
  assign elig1 = m1_req & (~lk_v_q |  lk_id_q);
  assign win_lock = win ? m1_lock : m0_lock;
`else
  assign elig0 = m0_req;
  assign elig1 = m1_req;
`endif

  assign take = (state_q == IDLE) & (elig0 | elig1);
  assign win  = (elig0 & elig1) ? ~last_q : elig1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    unique case (1'b1)
      (state_q == ISSUE): begin
        m0_gnt = ~owner_q;
        m1_gnt =  owner_q;
      end
      (state_q == RESP): begin
        m0_rvalid = ~owner_q;
        m1_rvalid =  owner_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    if (take) begin
      owner_d = win;
      last_d  = win;
      addr_d  = win ? m1_addr  : m0_addr;
      data_d  = win ? m1_wdata : m0_wdata;
      size_d  = win ? m1_wsize : m0_wsize;
    end
    // Store enable lives for the ISSUE cycle only.
    if (state_q == ISSUE) size_d = 2'b00;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= 2'b00;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_comb begin
    lk_v_d  = lk_v_q;
    lk_id_d = lk_id_q;
    if (take) begin
      lk_v_d  = win_lock;
      lk_id_d = win;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lk_v_q  <= 1'b0;
      lk_id_q <= 1'b0;
    end else begin
      lk_v_q  <= lk_v_d;
      lk_id_q <= lk_id_d;
    end
  end
`endif

  assign rdata   = d_data;
  assign d_addr  = addr_q;
  assign dw_data = data_q;
  assign dw_size = size_q;

endmodule
